// File: rtl/handle_sequencer.sv
// handle_sequencer
//   Round-robin front end sharing the handle translation table between
//   NUM_REQ requesters. Each accepted ALLOC / FREE / QUERY request is turned
//   into a short sequence of single-cycle READ/WRITE bus operations on the
//   handle-op window. The result and an error flag are returned to the
//   granted requester. Only one sequence is in flight at a time.
// Ports
//   i_clock / i_reset    clock (posedge), asynchronous active-high reset
//   i_req_valid/cmd/data per-requester request (cmd 0 ALLOC, 1 FREE, 2 QUERY)
//   o_req_ready          one-hot accept pulse
//   o_rsp_valid          one-hot completion pulse; o_rsp_err/o_rsp_data hold
//   o_op/o_address/o_data bus command (0 NOP, 1 READ, 2 WRITE)
//   i_bus_data           translator read data, valid within the READ cycle
module handle_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int HNDL_WIDTH = 15,
  parameter int NUM_REQ    = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_cmd,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic                          o_rsp_err,
  output logic [ADDR_WIDTH-1:0]         o_rsp_data,
  output logic [2:0]                    o_op,
  output logic [ADDR_WIDTH-1:0]         o_address,
  output logic [ADDR_WIDTH-1:0]         o_data,
  input  logic [ADDR_WIDTH-1:0]         i_bus_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;

  localparam logic [1:0] CMD_ALLOC = 2'd0;
  localparam logic [1:0] CMD_FREE  = 2'd1;
  localparam logic [1:0] CMD_QUERY = 2'd2;

  localparam logic [HNDL_WIDTH-1:0] NO_HNDL = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_A_RD, S_A_WR, S_F_WR, S_Q_RD, S_RESP
  } state_e;

  // Op-window address: MSB set, then HNDL_WIDTH ones, zeros, id in the LSBs.
  function automatic logic [ADDR_WIDTH-1:0] opa(input logic [HNDL_WIDTH-1:0] id);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1] = 1'b1;
    a[ADDR_WIDTH-2 -: HNDL_WIDTH] = '1;
    a[HNDL_WIDTH-1:0] = id;
    return a;
  endfunction

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   data_q, data_d;
  logic [HNDL_WIDTH-1:0]   id_q, id_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic                    found;
  logic [PW-1:0]           sel;
  int unsigned             idx;
  logic [1:0]              req_cmd;
  logic [ADDR_WIDTH-1:0]   req_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      data_q     <= '0;
      id_q       <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      id_q       <= id_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_rsp_err  = rsp_err_q;
  assign o_rsp_data = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    data_d      = data_q;
    id_d        = id_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_op        = OP_NOP;
    o_address   = '0;
    o_data      = '0;
    found       = 1'b0;
    sel         = '0;
    idx         = 0;

    // First valid requester at or after the round-robin pointer.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    req_cmd  = i_req_cmd[2*int'(sel) +: 2];
    req_data = i_req_data[ADDR_WIDTH*int'(sel) +: ADDR_WIDTH];

    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so no accept pulse escapes while reset is asserted.
        if (found && !i_reset) begin
          o_req_ready[sel] = 1'b1;
          gnt_d  = sel;
          data_d = req_data;
          id_d   = req_data[HNDL_WIDTH-1:0];
          ptr_d  = (32'(sel) == NUM_REQ - 1) ? '0 : sel + PW'(1);
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
          case (req_cmd)
            CMD_ALLOC: if (req_data != '0) state_d = S_A_RD;
            CMD_FREE:  if (req_data[HNDL_WIDTH-1:0] != NO_HNDL) state_d = S_F_WR;
            CMD_QUERY: if (req_data[HNDL_WIDTH-1:0] != NO_HNDL) state_d = S_Q_RD;
            default:   ;
          endcase
        end
      end
      S_A_RD: begin
        o_op      = OP_READ;
        o_address = opa(NO_HNDL);
        id_d      = i_bus_data[HNDL_WIDTH-1:0];
        if (i_bus_data[HNDL_WIDTH-1:0] == NO_HNDL) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else begin
          state_d = S_A_WR;
        end
      end
      S_A_WR: begin
        o_op       = OP_WRITE;
        o_address  = opa(id_q);
        o_data     = data_q;
        rsp_err_d  = 1'b0;
        rsp_data_d = ADDR_WIDTH'(id_q);
        state_d    = S_RESP;
      end
      S_F_WR: begin
        o_op       = OP_WRITE;
        o_address  = opa(id_q);
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
        state_d    = S_RESP;
      end
      S_Q_RD: begin
        o_op       = OP_READ;
        o_address  = opa(id_q);
        rsp_err_d  = 1'b0;
        rsp_data_d = i_bus_data;
        state_d    = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid[gnt_q] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
